// File: rtl/pipeline_hazard_ctrl_if.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Groups the signals between the IDU->EXU->MEM pipeline and the hazard
// sequencer into one bundle.
//   slave  : the hazard controller (reads pipeline status, drives enables)
//   master : the pipeline side (drives status, obeys hold/kill/bubble)
// Pipeline status : IDU_valid, IDU_rs1/rs2, IDU_rs1_used/rs2_used,
//                   EXU_valid, EXU_rd, EXU_R_Wen, EXU_mem_ren, EXU_jump,
//                   MEM_req, MEM_ack
// Control enables : pc_hold, IDU_hold, IDU_kill, EXU_hold, EXU_bubble, MEM_hold
// Observation     : ctrl_state, mem_timeout, perf_lu_cnt, perf_frz_cnt,
//                   perf_rd_cnt
// ----------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if;
  logic        IDU_valid;
  logic [4:0]  IDU_rs1;
  logic [4:0]  IDU_rs2;
  logic        IDU_rs1_used;
  logic        IDU_rs2_used;
  logic        EXU_valid;
  logic [4:0]  EXU_rd;
  logic        EXU_R_Wen;
  logic        EXU_mem_ren;
  logic        EXU_jump;
  logic        MEM_req;
  logic        MEM_ack;

  logic        pc_hold;
  logic        IDU_hold;
  logic        IDU_kill;
  logic        EXU_hold;
  logic        EXU_bubble;
  logic        MEM_hold;
  logic [1:0]  ctrl_state;
  logic        mem_timeout;
  logic [31:0] perf_lu_cnt;
  logic [31:0] perf_frz_cnt;
  logic [31:0] perf_rd_cnt;

  modport slave (
    input  IDU_valid, IDU_rs1, IDU_rs2, IDU_rs1_used, IDU_rs2_used,
           EXU_valid, EXU_rd, EXU_R_Wen, EXU_mem_ren, EXU_jump,
           MEM_req, MEM_ack,
    output pc_hold, IDU_hold, IDU_kill, EXU_hold, EXU_bubble, MEM_hold,
           ctrl_state, mem_timeout, perf_lu_cnt, perf_frz_cnt, perf_rd_cnt
  );

  modport master (
    output IDU_valid, IDU_rs1, IDU_rs2, IDU_rs1_used, IDU_rs2_used,
           EXU_valid, EXU_rd, EXU_R_Wen, EXU_mem_ren, EXU_jump,
           MEM_req, MEM_ack,
    input  pc_hold, IDU_hold, IDU_kill, EXU_hold, EXU_bubble, MEM_hold,
           ctrl_state, mem_timeout, perf_lu_cnt, perf_frz_cnt, perf_rd_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Stall/flush sequencer for the three-stage RV32I pipeline (IDU->EXU->MEM).
// Works beside the forwarding muxes: inserts a load-use bubble when the loaded
// value cannot be forwarded yet, freezes the whole pipe while data memory is
// busy, and kills wrong-path instructions after an EXU redirect.
//
// Ports
//   clk     : single clock, all state on the rising edge
//   rst     : synchronous active-high reset
//   ctrlIf  : pipeline_hazard_ctrl_if.slave (status in, enables/observation out)
//
// Parameters
//   REDIRECT_BUBBLES : extra IDU_kill cycles after a redirect (0..15)
//   MEM_TIMEOUT      : MEM_WAIT cycles before mem_timeout sets (2..65535)
//
// Optional feature macro: HAZ_PERF_EN
//   defined   -> three 32-bit wrapping performance counters
//   undefined -> perf_* outputs tied to zero, no counter flops
// ----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int unsigned REDIRECT_BUBBLES = 1,
  parameter int unsigned MEM_TIMEOUT      = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  pipeline_hazard_ctrl_if.slave  ctrlIf
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    REDIRECT = 2'd2
  } ctrlState_e;

  localparam logic [3:0]  RB_LOAD  = 4'(REDIRECT_BUBBLES);
  localparam logic [15:0] TO_LIMIT = 16'(MEM_TIMEOUT);

  ctrlState_e  r_state, w_nextState;
  logic [3:0]  r_rdCnt, w_nextRdCnt;
  logic [15:0] r_waitCnt, w_nextWaitCnt;
  logic        r_timeout, w_nextTimeout;

  logic w_freeze;
  logic w_redirect;
  logic w_luHazard;
  logic w_loadUse;

  // Hazard classification. A redirect is only accepted while unfrozen, so a
  // jump held in EXU during a freeze is picked up by the first free cycle.
  // The load-use stall is only needed in RUN: in REDIRECT the IDU holds a
  // bubble anyway, and a redirect in the same cycle discards the IDU instr.
  assign w_freeze   = ctrlIf.MEM_req & ~ctrlIf.MEM_ack;
  assign w_redirect = ~w_freeze & ctrlIf.EXU_valid & ctrlIf.EXU_jump;
  assign w_luHazard = ctrlIf.EXU_valid & ctrlIf.EXU_mem_ren & ctrlIf.EXU_R_Wen &
                      (ctrlIf.EXU_rd != 5'd0) & ctrlIf.IDU_valid &
                      ((ctrlIf.IDU_rs1_used & (ctrlIf.IDU_rs1 == ctrlIf.EXU_rd)) |
                       (ctrlIf.IDU_rs2_used & (ctrlIf.IDU_rs2 == ctrlIf.EXU_rd)));
  assign w_loadUse  = (r_state == RUN) & ~w_freeze & ~w_redirect & w_luHazard;

  // State register together with the redirect down-counter, the MEM_WAIT
  // cycle counter and the sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RUN;
      r_rdCnt   <= 4'd0;
      r_waitCnt <= 16'd0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_rdCnt   <= w_nextRdCnt;
      r_waitCnt <= w_nextWaitCnt;
      r_timeout <= w_nextTimeout;
    end
  end

  // Next-state logic. Freeze dominates: a REDIRECT interrupted by a freeze
  // parks in MEM_WAIT with its remaining bubble count intact and resumes
  // once memory releases the pipe. The wait counter saturates so a hung
  // memory can never wrap it back below the timeout threshold.
  always_comb begin
    w_nextState   = r_state;
    w_nextRdCnt   = r_rdCnt;
    w_nextWaitCnt = r_waitCnt;
    w_nextTimeout = r_timeout;
    if (w_freeze) begin
      if (r_state == MEM_WAIT) begin
        if (r_waitCnt != 16'hFFFF) begin
          w_nextWaitCnt = r_waitCnt + 16'd1;
        end
        if (w_nextWaitCnt >= TO_LIMIT) begin
          w_nextTimeout = 1'b1;
        end
      end else begin
        w_nextState   = MEM_WAIT;
        w_nextWaitCnt = 16'd0;
      end
    end else if (w_redirect) begin
      if (RB_LOAD != 4'd0) begin
        w_nextState = REDIRECT;
        w_nextRdCnt = RB_LOAD;
      end else begin
        w_nextState = RUN;
      end
    end else begin
      unique case (r_state)
        MEM_WAIT: w_nextState = (r_rdCnt != 4'd0) ? REDIRECT : RUN;
        REDIRECT: begin
          if (r_rdCnt != 4'd0) begin
            w_nextRdCnt = r_rdCnt - 4'd1;
          end
          if (r_rdCnt <= 4'd1) begin
            w_nextState = RUN;
          end
        end
        default: w_nextState = RUN;
      endcase
    end
  end

  // Output logic, strictly prioritised rst > freeze > redirect > load-use.
  // Everything is combinational so the enables act in the cycle the hazard
  // is seen.
  always_comb begin
    ctrlIf.pc_hold    = 1'b0;
    ctrlIf.IDU_hold   = 1'b0;
    ctrlIf.IDU_kill   = 1'b0;
    ctrlIf.EXU_hold   = 1'b0;
    ctrlIf.EXU_bubble = 1'b0;
    ctrlIf.MEM_hold   = 1'b0;
    if (rst) begin
      ctrlIf.IDU_kill   = 1'b1;
      ctrlIf.EXU_bubble = 1'b1;
    end else if (w_freeze) begin
      ctrlIf.pc_hold  = 1'b1;
      ctrlIf.IDU_hold = 1'b1;
      ctrlIf.EXU_hold = 1'b1;
      ctrlIf.MEM_hold = 1'b1;
    end else if (w_redirect || (r_state == REDIRECT)) begin
      ctrlIf.IDU_kill   = 1'b1;
      ctrlIf.EXU_bubble = 1'b1;
    end else if (w_loadUse) begin
      ctrlIf.pc_hold    = 1'b1;
      ctrlIf.IDU_hold   = 1'b1;
      ctrlIf.EXU_bubble = 1'b1;
    end
  end

  assign ctrlIf.ctrl_state  = r_state;
  assign ctrlIf.mem_timeout = r_timeout;

`ifdef HAZ_PERF_EN
  logic [31:0] r_perfLu;
  logic [31:0] r_perfFrz;
  logic [31:0] r_perfRd;

  // Performance counters: they count the same qualified events that drive
  // the enables, so a freeze masks any redirect or load-use in that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perfLu  <= 32'd0;
      r_perfFrz <= 32'd0;
      r_perfRd  <= 32'd0;
    end else begin
      if (w_loadUse)  r_perfLu  <= r_perfLu + 32'd1;
      if (w_freeze)   r_perfFrz <= r_perfFrz + 32'd1;
      if (w_redirect) r_perfRd  <= r_perfRd + 32'd1;
    end
  end

  assign ctrlIf.perf_lu_cnt  = r_perfLu;
  assign ctrlIf.perf_frz_cnt = r_perfFrz;
  assign ctrlIf.perf_rd_cnt  = r_perfRd;
`else
  assign ctrlIf.perf_lu_cnt  = 32'd0;
  assign ctrlIf.perf_frz_cnt = 32'd0;
  assign ctrlIf.perf_rd_cnt  = 32'd0;
`endif

endmodule
